// File: rtl/uart_parity_rx_pkg.sv
// Frame-format constants, FSM encoding and result payload shared by the UART receiver and transmitter.
package uart_parity_rx_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam bit          LSB_FIRST = 1'b1;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned IDX_W     = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 parity_err;
    logic                 frame_err;
  } rx_result_t;

  // Insert one serial bit into the data shift register in line order.
  function automatic logic [DATA_BITS-1:0] shift_in(input logic [DATA_BITS-1:0] sr,
                                                     input logic                 b);
    if (LSB_FIRST) return {b, sr[DATA_BITS-1:1]};
    else           return {sr[DATA_BITS-2:0], b};
  endfunction

endpackage

// File: rtl/uart_parity_rx_parity_calc.sv
// Expected parity bit for a data byte under even (odd=0) or odd (odd=1) parity.
module parity_calc
  import uart_parity_rx_pkg::*;
(
  input  logic [DATA_BITS-1:0] data,
  input  logic                 odd,
  output logic                 expected_parity_c
);

  assign expected_parity_c = (^data) ^ odd;

endmodule

// File: rtl/uart_parity_rx.sv
// UART receiver: 8 data bits LSB-first, one parity bit, one stop bit, with a single-entry
// holding register reporting parity, framing and overrun status.
module uart_parity_rx
  import uart_parity_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          ODD_PARITY   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rxd,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]           sync_q;
  logic [1:0]           flush_q;
  logic                 line_high_q;
  logic                 rxd_sync;
  logic                 start_edge_c;

  uart_state_e          state, state_next;
  logic [CNT_W-1:0]     cnt_q, cnt_next;
  logic [IDX_W-1:0]     idx_q, idx_next;
  logic [DATA_BITS-1:0] shreg_q, shreg_next;
  logic                 par_q, par_next;
  logic                 tick_c;
  logic                 done_c;
  logic                 exp_par_c;
  rx_result_t           held;

  // Two-flop synchronizer; flush_q marks when sync_q holds genuine line samples after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= 2'b11;
      flush_q     <= 2'b00;
      line_high_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rxd};
      flush_q     <= {flush_q[0], 1'b1};
      line_high_q <= flush_q[1] & rxd_sync;
    end
  end

  assign rxd_sync = sync_q[1];
  // A start needs a real high sample first, so a held-low line never re-triggers.
  assign start_edge_c = line_high_q & ~rxd_sync;
  assign tick_c       = (cnt_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt_q   <= cnt_next;
      idx_q   <= idx_next;
      shreg_q <= shreg_next;
      par_q   <= par_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt_q;
    idx_next   = idx_q;
    shreg_next = shreg_q;
    par_next   = par_q;
    done_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_edge_c) begin
          state_next = ST_START;
          cnt_next   = CNT_HALF;
        end
      end
      ST_START: begin
        if (!tick_c) begin
          cnt_next = cnt_q - CNT_W'(1);
        end else if (!rxd_sync) begin
          state_next = ST_DATA;
          cnt_next   = CNT_FULL;
          idx_next   = '0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!tick_c) begin
          cnt_next = cnt_q - CNT_W'(1);
        end else begin
          shreg_next = shift_in(shreg_q, rxd_sync);
          cnt_next   = CNT_FULL;
          if (idx_q == IDX_W'(DATA_BITS - 1)) state_next = ST_PARITY;
          else                                idx_next   = idx_q + IDX_W'(1);
        end
      end
      ST_PARITY: begin
        if (!tick_c) begin
          cnt_next = cnt_q - CNT_W'(1);
        end else begin
          par_next   = rxd_sync;
          cnt_next   = CNT_FULL;
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!tick_c) begin
          cnt_next = cnt_q - CNT_W'(1);
        end else begin
          done_c     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  parity_calc u_parity_calc (
    .data              (shreg_q),
    .odd               (ODD_PARITY),
    .expected_parity_c (exp_par_c)
  );

  // Holding register: a completing byte always wins over a same-cycle acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held     <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (done_c) begin
      held.data       <= shreg_q;
      held.parity_err <= par_q ^ exp_par_c;
      held.frame_err  <= ~rxd_sync;
      rx_valid        <= 1'b1;
      if (rx_valid && !rd_ack) overrun <= 1'b1;
    end else if (rd_ack) begin
      rx_valid <= 1'b0;
    end
  end

  assign rx_data    = held.data;
  assign parity_err = held.parity_err;
  assign frame_err  = held.frame_err;

endmodule

// File: tb/tb_uart_parity_rx.sv
// Self-checking bench: even- and odd-parity receivers on one line, checked against a byte-level model.
module tb_uart_parity_rx;
  import uart_parity_rx_pkg::*;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rxd;
  logic       rd_ack;
  logic [7:0] data_e, data_o;
  logic       valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, ovr_e, ovr_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic       m_valid, m_ovr, m_ferr, m_perr_e, m_perr_o;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  uart_parity_rx #(.CLKS_PER_BIT(CPB), .ODD_PARITY(1'b0)) dut_even (
    .clk(clk), .reset_n(reset_n), .rxd(rxd), .rd_ack(rd_ack),
    .rx_data(data_e), .rx_valid(valid_e), .parity_err(perr_e),
    .frame_err(ferr_e), .overrun(ovr_e)
  );

  uart_parity_rx #(.CLKS_PER_BIT(CPB), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .reset_n(reset_n), .rxd(rxd), .rd_ack(rd_ack),
    .rx_data(data_o), .rx_valid(valid_o), .parity_err(perr_o),
    .frame_err(ferr_o), .overrun(ovr_o)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".even.rx_valid"},   8'(valid_e), 8'(m_valid));
    chk({tag, ".even.rx_data"},    data_e,      m_data);
    chk({tag, ".even.parity_err"}, 8'(perr_e),  8'(m_perr_e));
    chk({tag, ".even.frame_err"},  8'(ferr_e),  8'(m_ferr));
    chk({tag, ".even.overrun"},    8'(ovr_e),   8'(m_ovr));
    chk({tag, ".odd.rx_valid"},    8'(valid_o), 8'(m_valid));
    chk({tag, ".odd.rx_data"},     data_o,      m_data);
    chk({tag, ".odd.parity_err"},  8'(perr_o),  8'(m_perr_o));
    chk({tag, ".odd.frame_err"},   8'(ferr_o),  8'(m_ferr));
    chk({tag, ".odd.overrun"},     8'(ovr_o),   8'(m_ovr));
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    m_perr_e = 1'b0; m_perr_o = 1'b0; m_data = 8'h00;
  endtask

  // Byte-level effect of one completed frame, from the parity/stop rules.
  task automatic model_done(input logic [7:0] d, input logic p, input logic stop, input logic ack);
    int ones;
    ones = $countones(d) + int'(p);
    if (m_valid && !ack) m_ovr = 1'b1;
    m_valid  = 1'b1;
    m_data   = d;
    m_perr_e = (ones % 2) != 0;
    m_perr_o = (ones % 2) != 1;
    m_ferr   = !stop;
  endtask

  task automatic ack_pulse();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned nbits);
    rxd = 1'b1;
    repeat (nbits * CPB) @(negedge clk);
  endtask

  // Drive one 11-bit frame; optionally pulse rd_ack on the completion cycle.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input logic ack_at_done);
    logic [10:0] fr;
    logic        was_valid;
    fr        = {stop, p, d, 1'b0};
    was_valid = m_valid;
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB - 6) @(negedge clk);
    if (!was_valid) chk("latency.before", 8'(valid_e), 8'h00);
    rd_ack = ack_at_done;
    @(negedge clk);
    rd_ack = 1'b0;
    model_done(d, p, stop, ack_at_done);
    if (!was_valid) chk("latency.after", 8'(valid_e), 8'h01);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    reset_n = 1'b0; rxd = 1'b1; rd_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    chk("reset.state", 8'(dut_even.state), 8'(ST_IDLE));
    reset_n = 1'b1;
    idle(2);

    send_frame(8'hBC, 1'b1, 1'b1, 1'b0);
    check_all("bc_par1");
    ack_pulse();
    idle(1);
    check_all("bc_acked");

    send_frame(8'hBC, 1'b0, 1'b1, 1'b0);
    check_all("bc_par0");
    ack_pulse();
    idle(1);

    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    check_all("55_stop0");
    ack_pulse();
    repeat (3 * CPB) @(negedge clk);
    idle(12);
    check_all("ferr_low_hold");
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    check_all("a5_after_ferr");

    ack_pulse();
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    idle(1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1);
    check_all("22_ack_at_done");
    ack_pulse();
    idle(1);

    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    idle(1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    check_all("22_overrun");
    idle(1);

    // 0x07 frame: line stays low from data bit 3 through 7, reset lands in bit 3.
    rxd = 1'b0; repeat (CPB) @(negedge clk);
    rxd = 1'b1; repeat (3 * CPB) @(negedge clk);
    rxd = 1'b0; repeat (CPB / 2) @(negedge clk);
    chk("pre_reset.state", 8'(dut_even.state), 8'(ST_DATA));
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("mid_reset");
    chk("mid_reset.state", 8'(dut_even.state), 8'(ST_IDLE));
    reset_n = 1'b1;
    repeat (CPB / 2 - 1) @(negedge clk);
    repeat (4 * CPB) @(negedge clk);
    idle(14);
    check_all("post_reset_tail");
    chk("post_reset_tail.state", 8'(dut_even.state), 8'(ST_IDLE));
    d = 8'($urandom);
    send_frame(d, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    check_all("after_reset_frame");

    ack_pulse();
    idle(1);
    rxd = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rxd = 1'b1;
    repeat (CPB) @(negedge clk);
    check_all("glitch");
    chk("glitch.state", 8'(dut_even.state), 8'(ST_IDLE));
    d = 8'($urandom);
    send_frame(d, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    check_all("after_glitch_frame");
    idle(1);

    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) ack_pulse();
      send_frame(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) != 0),
                 1'($urandom_range(0, 4) == 0));
      check_all($sformatf("rand%0d", k));
      idle($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_parity_rx.md
UART_PARITY_RX -- requirements
Module: uart_parity_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 4..65535.
REQ-002 Parameter ODD_PARITY, default 0: 0 = even parity, 1 = odd parity.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port rxd  input  1  serial line, idle high, asynchronous to clk.
REQ-006 Port rd_ack  input  1  consumer pulse; pops the held byte.
REQ-007 Port rx_data  output  8  last received byte.
REQ-008 Port rx_valid  output  1  a byte is held and not yet acknowledged.
REQ-009 Port parity_err  output  1  the held byte failed the parity check.
REQ-010 Port frame_err  output  1  the held byte had a low stop bit.
REQ-011 Port overrun  output  1  sticky flag: a new byte arrived while rx_valid=1.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer (both flops reset to 1) before any use.
REQ-013 Frame format SHALL be 1 start (0), 8 data LSB-first, 1 parity, 1 stop (1).
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE->START on a synchronized falling edge; the bit counter loads CLKS_PER_BIT/2-1.
REQ-016 In START at mid-bit, sample 0 -> DATA with the counter at CLKS_PER_BIT-1; sample 1 -> IDLE (glitch), with no flag change.
REQ-017 In DATA, sample once per CLKS_PER_BIT cycles into the shift register; move to PARITY after the 8th sample.
REQ-018 In PARITY, sample the parity bit p; error = (^data ^ p) != ODD_PARITY.
REQ-019 In STOP, sample the stop bit and return to IDLE on the cycle after the sample.
REQ-020 On that stop-sample cycle: rx_data <= shift register, rx_valid <= 1, parity_err <= parity result, frame_err <= (stop==0).
REQ-021 rx_data, parity_err and frame_err SHALL update together and be stable while rx_valid=1, except when overwritten by REQ-023.
REQ-022 rd_ack with rx_valid=1 SHALL clear rx_valid next cycle; rd_ack with rx_valid=0 SHALL be ignored.
REQ-023 On byte completion while rx_valid=1 and no rd_ack that cycle: overwrite rx_data and the error flags, and set overrun.
REQ-024 On simultaneous byte completion and rd_ack: the new byte wins, rx_valid stays 1, and overrun does not set.
REQ-025 overrun SHALL clear only on reset.
REQ-026 Latency from the stop-bit mid-sample to rx_valid high SHALL be 1 clk.
REQ-027 After a frame error, a new start SHALL only be detected after rxd_sync has been seen high at least one cycle.

Reset
REQ-028 On reset_n low, the FSM SHALL go to IDLE immediately, discarding any partial frame.
REQ-029 All outputs SHALL reset to 0, and the synchronizer flops to 1.
REQ-030 After deassertion mid-frame, the remaining line bits of that frame SHALL be treated as in REQ-027; a resynchronizing falling edge is required.

Structure
REQ-031 The FSM state encoding and frame-format constants (data width 8, bit order) SHALL live in a shared package, reused by the future transmitter.
REQ-032 The parity function SHALL be a sub-module parity_calc (8-bit data plus odd select in, 1-bit expected parity out), shared with the transmitter.
REQ-033 The synchronizer, baud counter, FSM and output holding register SHALL stay in uart_parity_rx; target size is under 250 lines.

Verification
REQ-034 Even parity, byte 0xBC, parity bit 1, stop 1 -> rx_data=0xBC, rx_valid=1, parity_err=0, frame_err=0.
REQ-035 Even parity, byte 0xBC, parity bit 0 -> rx_valid=1, parity_err=1; with ODD_PARITY=1 the same frame gives parity_err=0.
REQ-036 Byte 0x55 with stop bit 0 -> frame_err=1; a following good 0xA5 frame with idle gap -> frame_err=0 and rx_data=0xA5.
REQ-037 Two frames 0x11 then 0x22 with no rd_ack -> rx_data=0x22 and overrun=1; rd_ack at the 0x22 completion cycle instead -> overrun=0.
REQ-038 A 0.25-bit low glitch on rxd -> no rx_valid and the FSM back in IDLE; reset_n pulsed low mid-DATA -> all outputs 0 and the next full frame received correctly.
